// File: rtl/gcd_pkg.sv
// Shared types and constants for the binary (Stein) GCD engine.
package gcd_pkg;

  localparam int GCD_WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REDUCE = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_DONE   = 2'd3
  } gcd_state_t;

  // Width of the common power-of-two counter; it never exceeds WIDTH-1.
  function automatic int gcd_k_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/gcd_engine.sv
// Binary GCD engine: accepts an operand pair, reduces it one Stein step per
// cycle, and holds the result until the consumer takes it.
//
// state  | meaning
// IDLE   | in_ready high, waiting for an operand pair
// REDUCE | one Stein step per cycle until a_q or b_q reaches zero
// SHIFT  | restore the common power of two into the result
// DONE   | out_valid high, result held until out_ready
module gcd_engine
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH_DEFAULT,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] gcd,
  output logic             zero_in,
  output logic [CNT_W-1:0] cycles
);

  localparam int K_W = gcd_k_width(WIDTH);

  gcd_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [K_W-1:0]   k_q, k_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] gcd_q, gcd_d;
  logic             zero_in_q, zero_in_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;

  logic [WIDTH-1:0] a_step, b_step;
  logic             k_inc;

  // Single Stein step; both-odd subtraction never underflows thanks to the compare.
  always_comb begin
    a_step = a_q;
    b_step = b_q;
    k_inc  = 1'b0;
    if (!a_q[0] && !b_q[0]) begin
      a_step = a_q >> 1;
      b_step = b_q >> 1;
      k_inc  = 1'b1;
    end else if (!a_q[0]) begin
      a_step = a_q >> 1;
    end else if (!b_q[0]) begin
      b_step = b_q >> 1;
    end else if (a_q >= b_q) begin
      a_step = (a_q - b_q) >> 1;
    end else begin
      b_step = (b_q - a_q) >> 1;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    k_d       = k_q;
    cnt_d     = cnt_q;
    gcd_d     = gcd_q;
    zero_in_d = zero_in_q;
    cycles_d  = cycles_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d   = a;
          b_d   = b;
          k_d   = '0;
          cnt_d = '0;
          if (a == '0 || b == '0) begin
            gcd_d     = a | b;
            zero_in_d = (a == '0) && (b == '0);
            cycles_d  = '0;
            state_d   = ST_DONE;
          end else begin
            state_d = ST_REDUCE;
          end
        end
      end
      ST_REDUCE: begin
        a_d   = a_step;
        b_d   = b_step;
        k_d   = k_q + K_W'(k_inc);
        cnt_d = cnt_q + CNT_W'(1);
        if (a_step == '0 || b_step == '0) begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        gcd_d     = (a_q | b_q) << k_q;
        zero_in_d = 1'b0;
        cycles_d  = cnt_q;
        state_d   = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      k_q       <= '0;
      cnt_q     <= '0;
      gcd_q     <= '0;
      zero_in_q <= 1'b0;
      cycles_q  <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      k_q       <= k_d;
      cnt_q     <= cnt_d;
      gcd_q     <= gcd_d;
      zero_in_q <= zero_in_d;
      cycles_q  <= cycles_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign gcd       = gcd_q;
  assign zero_in   = zero_in_q;
  assign cycles    = cycles_q;

endmodule

// File: tb/tb_gcd_engine.sv
// Self-checking bench for gcd_engine: Euclid reference model, directed vectors
// with literal expectations, backpressure, reset abort, and random pairs.
module tb_gcd_engine;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, out_valid, out_ready, zero_in;
  logic [31:0] a, b, gcd;
  logic [7:0]  cycles;

  logic        in_valid8, in_ready8, out_valid8, out_ready8, zero_in8;
  logic [7:0]  a8, b8, gcd8, cycles8;

  gcd_engine #(.WIDTH(32), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .gcd(gcd), .zero_in(zero_in), .cycles(cycles)
  );

  gcd_engine #(.WIDTH(8), .CNT_W(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8),
    .gcd(gcd8), .zero_in(zero_in8), .cycles(cycles8)
  );

  int checks   = 0;
  int failures = 0;
  longint cyc  = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint unsigned g;
    logic            z;
    logic            zp;
    int              c;
    longint          acc;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint unsigned ref_gcd(input longint unsigned x, input longint unsigned y);
    longint unsigned t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Compare process for the 32-bit engine: every DONE cycle is checked against the queue head.
  initial begin
    logic            head_seen;
    longint unsigned head_cycles;
    longint          lat;
    head_seen   = 1'b0;
    head_cycles = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        head_seen = 1'b0;
      end else if (out_valid) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_out_valid: got 1 expected 0 (t=%0t)", $time);
        end else begin
          chk("gcd", gcd, q[0].g);
          chk("zero_in", zero_in, q[0].z);
          chk("in_ready_in_done", in_ready, 0);
          if (!head_seen) begin
            head_seen   = 1'b1;
            head_cycles = cycles;
            lat = cyc - q[0].acc + 1;
            if (q[0].c >= 0) chk("cycles", cycles, q[0].c);
            chk("latency_vs_cycles", lat, cycles + (q[0].zp ? 2 : 3));
            chk("latency_bound", lat <= 66, 1);
          end else begin
            chk("cycles_hold", cycles, head_cycles);
          end
          if (out_ready) begin
            void'(q.pop_front());
            head_seen = 1'b0;
          end
        end
      end
    end
  end

  task automatic send32(input logic [31:0] av, input logic [31:0] bv,
                        input longint exp_g, input int exp_c);
    exp_t e;
    int   guard;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 300) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("ready_before_send", in_ready, 1);
    e.g = ref_gcd(av, bv);
    if (exp_g >= 0) chk("model_pin", e.g, exp_g);
    e.z   = (av == 0) && (bv == 0);
    e.zp  = (av == 0) || (bv == 0);
    e.c   = exp_c;
    e.acc = cyc;
    q.push_back(e);
    a = av;
    b = bv;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input int limit);
    int guard;
    guard = 0;
    while (q.size() != 0 && guard < limit) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("drain_timeout", q.size(), 0);
  endtask

  initial begin
    int          guard;
    int          lat8;
    int unsigned m;
    logic [31:0] av, bv;
    logic [7:0]  x, y;

    reset = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; out_ready8 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_gcd", gcd, 0);
    chk("rst_zero_in", zero_in, 0);
    chk("rst_cycles", cycles, 0);
    chk("rst_in_ready8", in_ready8, 1);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed vectors: literal gcd and Stein step counts worked by hand.
    send32(48, 18, 6, 6);                             drain(100);
    send32(0, 0, 0, 0);                               drain(10);
    send32(0, 7, 7, 0);                               drain(10);
    send32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF, 1); drain(100);
    send32(32'h8000_0000, 32'h4000_0000, 64'h4000_0000, 32); drain(100);
    send32(17, 13, 1, 6);                             drain(100);
    send32(21, 14, 7, 3);                             drain(100);

    // Backpressure: result must hold and stray in_valid pulses must be ignored.
    out_ready = 1'b0;
    send32(12, 8, 4, 5);
    guard = 0;
    while (!out_valid && guard < 100) begin
      chk("bp_busy_in_ready", in_ready, 0);
      @(posedge clk); #1;
      guard++;
    end
    chk("bp_out_valid_seen", out_valid, 1);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      a = 99;
      b = 33;
      chk("bp_hold_in_ready", in_ready, 0);
      chk("bp_hold_out_valid", out_valid, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain(10);

    // Reset in the middle of a long reduction.
    send32(1000000007, 998244353, -1, -1);
    repeat (5) @(posedge clk);
    #1;
    chk("busy_before_reset", in_ready, 0);
    reset = 1'b1;
    q.delete();
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_gcd", gcd, 0);
    chk("abort_cycles", cycles, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    send32(21, 14, 7, 3);
    drain(100);

    // Random 32-bit pairs: plain, shared odd factor, and shared powers of two.
    for (int i = 0; i < 300; i++) begin
      m = $urandom_range(1, 4095);
      case (i % 3)
        0: begin av = $urandom; bv = $urandom; end
        1: begin av = $urandom_range(1, 100000) * m; bv = $urandom_range(1, 100000) * m; end
        default: begin
          av = $urandom << $urandom_range(0, 24);
          bv = $urandom << $urandom_range(0, 24);
        end
      endcase
      if (i % 50 == 7) av = '0;
      send32(av, bv, -1, -1);
      drain(100);
    end

    // Random 8-bit pairs on the narrow instance, checked inline.
    for (int i = 0; i < 1500; i++) begin
      x = 8'($urandom);
      y = 8'($urandom);
      if (i == 0) begin x = 0;   y = 0;   end
      if (i == 1) begin x = 255; y = 255; end
      if (i == 2) begin x = 128; y = 64;  end
      if (i == 3) begin x = 0;   y = 200; end
      chk("ready8", in_ready8, 1);
      a8 = x;
      b8 = y;
      in_valid8 = 1'b1;
      @(posedge clk); #1;
      in_valid8 = 1'b0;
      lat8 = 2;
      while (!out_valid8 && lat8 < 40) begin
        @(posedge clk); #1;
        lat8++;
      end
      chk("out_valid8_seen", out_valid8, 1);
      chk("gcd8", gcd8, ref_gcd(x, y));
      chk("zero_in8", zero_in8, (x == 0) && (y == 0));
      chk("latency8_bound", lat8 <= 18, 1);
      chk("latency8_vs_cycles", lat8, cycles8 + ((x == 0 || y == 0) ? 2 : 3));
      @(posedge clk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
